axi4_rd_arbiter: RTL and testbench

- Two-requester AR/R arbiter that shares one AXI4 slave read port between two AXI4 masters (s0, s1).
- Each burst is granted round-robin and serialised: one outstanding read burst at a time, owned by one requester from AR acceptance until the RLAST handshake.
- Sits between the master BFMs/IP and a single memory-side slave, and checks beat count against ARLEN.

---
 rtl/axi4_arb_pkg.sv | 46 ++++
 rtl/axi4_rd_arbiter_rr_arb2.sv | 21 ++
 rtl/axi4_rd_arbiter.sv | 155 +++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : axi4_arb_pkg
// Purpose  : Shared widths, AR/R field layouts and FSM states for axi4_rd_arbiter
// Revision : 1.0 - initial release
// ============================================================================
package axi4_arb_pkg;

    localparam int AR_FIXED_W = 61;
    localparam int R_FIXED_W  = 3;

    function automatic int ab_w(input int i);
        return i + AR_FIXED_W;
    endfunction

    function automatic int rb_w(input int n, input int i);
        return i + 8 * n + R_FIXED_W;
    endfunction

    // AR payload below the ID; the ID width is a module parameter, so the full
    // beat struct is completed inside the module.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  region;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } ar_ctrl_t;

    typedef struct packed {
        logic [1:0] resp;
        logic       last;
    } r_tail_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi4_rd_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin picker; on a tie the requester that did not
//            own the bus last time wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       idx_o,
    output logic       any_o
);

    assign idx_o = req_i[1] & (~req_i[0] | ~last_i);
    assign any_o = |req_i;
    assign gnt_o = any_o ? (idx_o ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: rtl/axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rd_arbiter
// Purpose  : Serialising round-robin AR/R arbiter sharing one AXI4 read slave
//            between two masters, with sticky burst-length checking.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rd_arbiter
    import axi4_arb_pkg::*;
#(
    parameter  int N    = 1,
    parameter  int I    = 1,
    localparam int AB_W = ab_w(I),
    localparam int RB_W = rb_w(N, I)
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            s0_ar_valid,
    output logic            s0_ar_ready,
    input  logic [AB_W-1:0] s0_ar_beat,
    output logic            s0_r_valid,
    input  logic            s0_r_ready,
    output logic [RB_W-1:0] s0_r_beat,
    input  logic            s1_ar_valid,
    output logic            s1_ar_ready,
    input  logic [AB_W-1:0] s1_ar_beat,
    output logic            s1_r_valid,
    input  logic            s1_r_ready,
    output logic [RB_W-1:0] s1_r_beat,
    output logic            m_ar_valid,
    input  logic            m_ar_ready,
    output logic [AB_W-1:0] m_ar_beat,
    input  logic            m_r_valid,
    output logic            m_r_ready,
    input  logic [RB_W-1:0] m_r_beat,
    output logic            owner,
    output logic            busy,
    output logic            len_err
);

    typedef struct packed {
        logic [I-1:0] id;
        ar_ctrl_t     ctrl;
    } ar_beat_t;

    typedef struct packed {
        logic [I-1:0]   id;
        logic [8*N-1:0] data;
        r_tail_t        tail;
    } r_beat_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [8:0] beat_cnt_q, beat_cnt_d;
    logic       len_err_q, len_err_d;
    ar_beat_t   ar_q, ar_d;

    logic [1:0] gnt;
    logic       win_idx;
    logic       win_any;
    logic       own_r_ready;
    logic       r_hs;
    r_beat_t    r_view;

    rr_arb2 u_rr_arb2 (
        .req_i  ({s1_ar_valid, s0_ar_valid}),
        .last_i (owner_q),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (win_any)
    );

    assign r_view      = r_beat_t'(m_r_beat);
    assign own_r_ready = owner_q ? s1_r_ready : s0_r_ready;
    assign r_hs        = (state_q == DATA) && m_r_valid && own_r_ready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            owner_q    <= 1'b1;
            beat_cnt_q <= 9'd0;
            len_err_q  <= 1'b0;
            ar_q       <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
            ar_q       <= ar_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        beat_cnt_d  = beat_cnt_q;
        len_err_d   = len_err_q;
        ar_d        = ar_q;
        s0_ar_ready = 1'b0;
        s1_ar_ready = 1'b0;
        m_ar_valid  = 1'b0;
        m_r_ready   = 1'b0;
        s0_r_valid  = 1'b0;
        s1_r_valid  = 1'b0;
        s0_r_beat   = '0;
        s1_r_beat   = '0;
        case (state_q)
            IDLE: begin
                s0_ar_ready = gnt[0];
                s1_ar_ready = gnt[1];
                if (win_any) begin
                    ar_d       = ar_beat_t'(win_idx ? s1_ar_beat : s0_ar_beat);
                    owner_d    = win_idx;
                    beat_cnt_d = 9'd0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_r_ready = own_r_ready;
                if (owner_q) begin
                    s1_r_valid = m_r_valid;
                    s1_r_beat  = m_r_beat;
                end else begin
                    s0_r_valid = m_r_valid;
                    s0_r_beat  = m_r_beat;
                end
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    // beat_cnt holds the index of the beat being handshaken
                    if ((r_view.tail.last && (beat_cnt_q != {1'b0, ar_q.ctrl.len})) ||
                        (!r_view.tail.last && (beat_cnt_q == {1'b0, ar_q.ctrl.len}))) begin
                        len_err_d = 1'b1;
                    end
                    if (r_view.tail.last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_ar_beat = ar_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);
    assign len_err   = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_rd_arbiter
// Purpose  : Self-checking bench for axi4_rd_arbiter against a burst-level model
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi4_rd_arbiter;

    localparam int N    = 4;
    localparam int I    = 4;
    localparam int AB_W = I + 61;
    localparam int RB_W = I + 8 * N + 3;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic            s0_ar_valid, s0_ar_ready, s0_r_valid, s0_r_ready;
    logic            s1_ar_valid, s1_ar_ready, s1_r_valid, s1_r_ready;
    logic [AB_W-1:0] s0_ar_beat, s1_ar_beat, m_ar_beat;
    logic [RB_W-1:0] s0_r_beat, s1_r_beat, m_r_beat;
    logic            m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic            owner, busy, len_err;

    int checks = 0;
    int errors = 0;

    // Model: who owned the bus last, sticky error, and AR requests still pending
    int              m_owner;
    bit              m_err;
    bit              pend0, pend1;
    logic [AB_W-1:0] beat0, beat1;

    always #5 ACLK = ~ACLK;

    axi4_rd_arbiter #(.N(N), .I(I)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s0_ar_valid (s0_ar_valid),
        .s0_ar_ready (s0_ar_ready),
        .s0_ar_beat  (s0_ar_beat),
        .s0_r_valid  (s0_r_valid),
        .s0_r_ready  (s0_r_ready),
        .s0_r_beat   (s0_r_beat),
        .s1_ar_valid (s1_ar_valid),
        .s1_ar_ready (s1_ar_ready),
        .s1_ar_beat  (s1_ar_beat),
        .s1_r_valid  (s1_r_valid),
        .s1_r_ready  (s1_r_ready),
        .s1_r_beat   (s1_r_beat),
        .m_ar_valid  (m_ar_valid),
        .m_ar_ready  (m_ar_ready),
        .m_ar_beat   (m_ar_beat),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_beat    (m_r_beat),
        .owner       (owner),
        .busy        (busy),
        .len_err     (len_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AB_W-1:0] rand_ar(input int len);
        logic [95:0]     r;
        logic [AB_W-1:0] b;
        r       = {$urandom, $urandom, $urandom};
        b       = r[AB_W-1:0];
        b[24:17] = len[7:0];
        return b;
    endfunction

    task automatic new_req(input int idx, input int len);
        if (idx == 0 && !pend0) beat0 = rand_ar(len);
        if (idx == 1 && !pend1) beat1 = rand_ar(len);
    endtask

    task automatic do_reset();
        ARESET      = 1'b1;
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        s0_ar_beat  = '0;   s1_ar_beat  = '0;
        s0_r_ready  = 1'b0; s1_r_ready  = 1'b0;
        m_ar_ready  = 1'b0; m_r_valid   = 1'b0; m_r_beat = '0;
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET  = 1'b0;
        m_owner = 1;
        m_err   = 1'b0;
        pend0   = 1'b0;
        pend1   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ar_rdy0"}, s0_ar_ready, 1'b0);
        chk({tag, "_ar_rdy1"}, s1_ar_ready, 1'b0);
        chk({tag, "_r_vld0"},  s0_r_valid,  1'b0);
        chk({tag, "_r_vld1"},  s1_r_valid,  1'b0);
        chk({tag, "_m_ar_vld"}, m_ar_valid, 1'b0);
        chk({tag, "_m_r_rdy"}, m_r_ready,   1'b0);
        chk({tag, "_busy"},    busy,        1'b0);
        chk({tag, "_owner"},   owner,       1'b1);
        chk({tag, "_len_err"}, len_err,     1'b0);
    endtask

    // One complete burst, entered and left at a negedge with the DUT idle.
    // nb_ovr>0 makes the slave send that many beats instead of len+1;
    // abort>0 returns after that many R handshakes, leaving the burst open.
    task automatic run_burst(input bit v0, input bit v1, input int stall,
                             input int nb_ovr, input bit rrand, input int abort);
        int              w, len, nb, k, cyc;
        logic [AB_W-1:0] wb;
        logic [RB_W-1:0] rb;
        logic [63:0]     t;
        bit              last, rdy, vld, hs;
        s0_ar_valid = v0; s0_ar_beat = beat0;
        s1_ar_valid = v1; s1_ar_beat = beat1;
        pend0 = v0; pend1 = v1;
        w = (v0 && v1) ? (1 - m_owner) : (v1 ? 1 : 0);
        #1;
        chk("grant_rdy0", s0_ar_ready, w == 0);
        chk("grant_rdy1", s1_ar_ready, w == 1);
        chk("grant_m_ar_vld", m_ar_valid, 1'b0);
        wb      = (w == 0) ? beat0 : beat1;
        len     = int'(wb[24:17]);
        m_owner = w;
        if (w == 0) pend0 = 1'b0; else pend1 = 1'b0;
        @(negedge ACLK);
        if (w == 0) s0_ar_valid = 1'b0; else s1_ar_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            m_ar_ready = (i == stall);
            #1;
            chk("addr_m_ar_vld", m_ar_valid, 1'b1);
            chk("addr_beat", m_ar_beat, wb);
            chk("addr_rdy0", s0_ar_ready, 1'b0);
            chk("addr_rdy1", s1_ar_ready, 1'b0);
            chk("addr_owner", owner, w[0]);
            chk("addr_busy", busy, 1'b1);
            @(negedge ACLK);
        end
        m_ar_ready = 1'b0;
        nb  = (nb_ovr > 0) ? nb_ovr : len + 1;
        k   = 0;
        cyc = 0;
        while (k < nb && cyc < 500 && !(abort > 0 && k == abort)) begin
            last   = (k == nb - 1);
            t      = {$urandom, $urandom};
            rb     = t[RB_W-1:0];
            rb[0]  = last;
            m_r_beat = rb;
            vld    = ($urandom_range(0, 3) != 0);
            hs     = 1'b0;
            while (!hs && cyc < 500) begin
                if (!vld) vld = ($urandom_range(0, 1) != 0);
                rdy = rrand ? ($urandom_range(0, 1) != 0) : 1'b1;
                m_r_valid = vld;
                if (w == 0) begin
                    s0_r_ready = rdy; s1_r_ready = ($urandom_range(0, 1) != 0);
                end else begin
                    s1_r_ready = rdy; s0_r_ready = ($urandom_range(0, 1) != 0);
                end
                #1;
                chk("data_own_vld",  (w == 0) ? s0_r_valid : s1_r_valid, vld);
                chk("data_own_beat", (w == 0) ? s0_r_beat  : s1_r_beat,  rb);
                chk("data_oth_vld",  (w == 0) ? s1_r_valid : s0_r_valid, 1'b0);
                chk("data_oth_beat", (w == 0) ? s1_r_beat  : s0_r_beat,  {RB_W{1'b0}});
                chk("data_m_r_rdy",  m_r_ready, rdy);
                chk("data_ar_rdy",   s0_ar_ready | s1_ar_ready, 1'b0);
                hs = vld && rdy;
                @(negedge ACLK);
                cyc++;
            end
            if (hs) begin
                if ((last && k != len) || (!last && k == len)) m_err = 1'b1;
                k++;
            end
        end
        if (cyc >= 500) begin
            checks++;
            errors++;
            $error("FAIL data_timeout observed=%0d beats expected=%0d beats", k, nb);
        end
        if (abort > 0) return;
        m_r_valid = 1'b0;
        #1;
        chk("end_busy", busy, 1'b0);
        chk("end_len_err", len_err, m_err);
        chk("end_owner", owner, w[0]);
    endtask

    initial begin
        do_reset();
        #1;
        check_quiet("reset");
        chk("reset_m_ar_beat", m_ar_beat, {AB_W{1'b0}});

        // Single s0 request, addr 0x1000, four beats
        new_req(0, 3);
        beat0[60:29] = 32'h0000_1000;
        run_burst(1'b1, 1'b0, 0, 0, 1'b0, 0);

        // Ties: s0 first, then the waiting s1, then s0 again
        do_reset();
        new_req(0, 1); new_req(1, 2);
        run_burst(1'b1, 1'b1, 0, 0, 1'b0, 0);
        new_req(0, 2);
        run_burst(1'b1, 1'b1, 0, 0, 1'b0, 0);
        new_req(1, 0);
        run_burst(1'b1, 1'b1, 0, 0, 1'b0, 0);

        // AR stall with the other requester held off, R ready toggling
        new_req(0, 5); new_req(1, 2);
        run_burst(1'b1, 1'b1, 5, 0, 1'b1, 0);

        // Randomised bursts, occasionally with a wrong beat count
        for (int it = 0; it < 20; it++) begin
            bit a0, a1;
            a0 = pend0 || ($urandom_range(0, 1) != 0);
            a1 = pend1 || ($urandom_range(0, 1) != 0);
            if (!a0 && !a1) a0 = 1'b1;
            if (a0) new_req(0, $urandom_range(0, 7));
            if (a1) new_req(1, $urandom_range(0, 7));
            run_burst(a0, a1, $urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 0, 1'b1, 0);
        end
        if (pend0 || pend1) run_burst(pend0, pend1, 0, 0, 1'b1, 0);

        // Length error: len=1 but slave ends after one beat, then a good burst
        do_reset();
        new_req(0, 1);
        run_burst(1'b1, 1'b0, 0, 1, 1'b0, 0);
        new_req(1, 2);
        run_burst(1'b0, 1'b1, 1, 0, 1'b1, 0);

        // Reset part-way through a four-beat burst
        new_req(0, 3);
        run_burst(1'b1, 1'b0, 0, 0, 1'b0, 2);
        ARESET     = 1'b1;
        m_r_valid  = 1'b1;
        s0_r_ready = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_quiet("midrst");
        m_owner = 1; m_err = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
        m_r_valid = 1'b0;
        new_req(1, 2);
        run_burst(1'b0, 1'b1, 2, 0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
